// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the requester and memory-side signals of mem_arbiter.
//   Fetch port : if_req, if_addr -> if_gnt, if_rvalid, if_rdata
//   LSU port   : ls_req, ls_we, ls_lock, ls_addr, ls_wdata -> ls_gnt, ls_rvalid, ls_rdata
//   Memory     : mem_rw, mem_addr, mem_wdata -> mem_rdata (combinational read)
// slave  : the arbiter's view.
// master : the environment's view (requesters plus the memory).
interface mem_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic              ls_lock;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;

    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_lock, ls_addr, ls_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
        output mem_rw, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_lock, ls_addr, ls_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
        input  mem_rw, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch port (read-only)
// and the load/store port (read/write), one access per cycle.
// LSU has fixed priority, bounded by an IF starvation counter; an LSU lock keeps
// ownership across read-modify-write sequences. Read data is registered and returned
// one cycle after the grant.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   io_bus  : mem_arbiter_if.slave (fetch port, LSU port, memory drive)
module mem_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    mem_arbiter_if.slave   io_bus
);
    localparam logic [3:0] StarveLim = 4'(STARVE_MAX);

    typedef enum logic {StOpen, StLocked} lock_e;

    lock_e             r_lock, w_lock_next;
    logic [3:0]        r_starve, w_starve_next;
    logic              r_if_pend, r_ls_pend;
    logic [DATA_W-1:0] r_if_rdata, r_ls_rdata;

    logic              w_if_gnt, w_ls_gnt, w_ls_load;
    logic              w_mem_rw;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    // Grant decision; gated by reset so nothing reaches memory while reset is held.
    always_comb begin
        w_if_gnt = 1'b0;
        w_ls_gnt = 1'b0;
        if (i_rst_n) begin
            if (r_lock == StLocked) begin
                // Lock overrides starvation: IF waits even if memory sits idle.
                w_ls_gnt = io_bus.ls_req;
            end else if (io_bus.if_req && (r_starve == StarveLim)) begin
                w_if_gnt = 1'b1;
            end else if (io_bus.ls_req) begin
                w_ls_gnt = 1'b1;
            end else if (io_bus.if_req) begin
                w_if_gnt = 1'b1;
            end
        end
    end

    assign w_ls_load = w_ls_gnt & ~io_bus.ls_we;

    // Memory drive: everything zero when idle, so a write needs an LSU grant.
    always_comb begin
        w_mem_rw    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_ls_gnt) begin
            w_mem_rw    = io_bus.ls_we;
            w_mem_addr  = io_bus.ls_addr;
            w_mem_wdata = io_bus.ls_wdata;
        end else if (w_if_gnt) begin
            w_mem_addr  = io_bus.if_addr;
        end
    end

    // Next-state: lock follows ls_lock on LSU grants only; starvation counter saturates.
    always_comb begin
        w_lock_next   = r_lock;
        w_starve_next = r_starve;
        if (w_ls_gnt) begin
            w_lock_next = io_bus.ls_lock ? StLocked : StOpen;
        end
        if (!io_bus.if_req || w_if_gnt) begin
            w_starve_next = 4'd0;
        end else if (r_starve != StarveLim) begin
            w_starve_next = r_starve + 4'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lock     <= StOpen;
            r_starve   <= 4'd0;
            r_if_pend  <= 1'b0;
            r_ls_pend  <= 1'b0;
            r_if_rdata <= '0;
            r_ls_rdata <= '0;
        end else begin
            r_lock    <= w_lock_next;
            r_starve  <= w_starve_next;
            r_if_pend <= w_if_gnt;
            r_ls_pend <= w_ls_load;
            if (w_if_gnt) begin
                r_if_rdata <= io_bus.mem_rdata;
            end
            if (w_ls_load) begin
                r_ls_rdata <= io_bus.mem_rdata;
            end
        end
    end

    assign io_bus.if_gnt    = w_if_gnt;
    assign io_bus.ls_gnt    = w_ls_gnt;
    assign io_bus.if_rvalid = r_if_pend;
    assign io_bus.ls_rvalid = r_ls_pend;
    assign io_bus.if_rdata  = r_if_rdata;
    assign io_bus.ls_rdata  = r_ls_rdata;
    assign io_bus.mem_rw    = w_mem_rw;
    assign io_bus.mem_addr  = w_mem_addr;
    assign io_bus.mem_wdata = w_mem_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a scoreboard. The driver pushes the expected
// grant/memory drive for each cycle and the expected read responses (one cycle later);
// a monitor on the falling edge pops and compares. Unwritten memory words read as
// 0xC0DE0000 | addr.
module tb_mem_arbiter;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    // Memory model: synchronous write, combinational read.
    logic [DW-1:0] mem [1024];
    logic [1023:0] written;
    always @(posedge clk) begin
        if (!rst_n) begin
            written <= '0;
        end else if (bus.mem_rw) begin
            mem[bus.mem_addr]     <= bus.mem_wdata;
            written[bus.mem_addr] <= 1'b1;
        end
    end
    assign bus.mem_rdata = written[bus.mem_addr] ? mem[bus.mem_addr]
                                                 : (32'hC0DE_0000 | {22'd0, bus.mem_addr});

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        int          cyc;
        logic        ig;
        logic        lg;
        logic        rw;
        logic [AW-1:0] addr;
        logic        chk_wd;
        logic [DW-1:0] wd;
    } gexp_t;

    typedef struct {
        int          cyc;
        logic [DW-1:0] d;
    } rexp_t;

    gexp_t gq[$];
    rexp_t ifq[$];
    rexp_t lsq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle and record what the DUT must do in it and the cycle after.
    task automatic step(input logic rstn, input logic ifr, input logic [AW-1:0] ifa,
                        input logic lsr, input logic lsw, input logic lsl,
                        input logic [AW-1:0] lsa, input logic [DW-1:0] lswd,
                        input logic e_if, input logic e_ls, input logic [DW-1:0] e_d);
        gexp_t g;
        @(posedge clk);
        #1;
        if (!rstn) begin
            // Asserting reset drops responses still in flight.
            ifq.delete();
            lsq.delete();
        end
        rst_n        = rstn;
        bus.if_req   = ifr;
        bus.if_addr  = ifa;
        bus.ls_req   = lsr;
        bus.ls_we    = lsw;
        bus.ls_lock  = lsl;
        bus.ls_addr  = lsa;
        bus.ls_wdata = lswd;
        g.cyc    = cyc;
        g.ig     = e_if;
        g.lg     = e_ls;
        g.rw     = e_ls & lsw;
        g.addr   = e_ls ? lsa : (e_if ? ifa : '0);
        g.chk_wd = !e_if;
        g.wd     = e_ls ? lswd : '0;
        gq.push_back(g);
        if (e_if) ifq.push_back('{cyc: cyc + 1, d: e_d});
        if (e_ls && !lsw) lsq.push_back('{cyc: cyc + 1, d: e_d});
    endtask

    // Monitor
    always @(negedge clk) begin : monitor
        gexp_t g;
        rexp_t r;
        if (gq.size() > 0 && gq[0].cyc == cyc) begin
            g = gq.pop_front();
            chk("if_gnt", 32'(bus.if_gnt), 32'(g.ig));
            chk("ls_gnt", 32'(bus.ls_gnt), 32'(g.lg));
            chk("mem_rw", 32'(bus.mem_rw), 32'(g.rw));
            chk("mem_addr", 32'(bus.mem_addr), 32'(g.addr));
            if (g.chk_wd) chk("mem_wdata", bus.mem_wdata, g.wd);
        end
        if (ifq.size() > 0 && ifq[0].cyc == cyc) begin
            r = ifq.pop_front();
            chk("if_rvalid", 32'(bus.if_rvalid), 32'd1);
            chk("if_rdata", bus.if_rdata, r.d);
        end else begin
            chk("if_rvalid idle", 32'(bus.if_rvalid), 32'd0);
        end
        if (lsq.size() > 0 && lsq[0].cyc == cyc) begin
            r = lsq.pop_front();
            chk("ls_rvalid", 32'(bus.ls_rvalid), 32'd1);
            chk("ls_rdata", bus.ls_rdata, r.d);
        end else begin
            chk("ls_rvalid idle", 32'(bus.ls_rvalid), 32'd0);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        // Contention pattern with STARVE_MAX=4: bit i set = IF wins step i.
        logic [9:0] cpat;
        cpat = 10'b10000_10000;

        rst_n        = 1'b0;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.ls_req   = 1'b0;
        bus.ls_we    = 1'b0;
        bus.ls_lock  = 1'b0;
        bus.ls_addr  = '0;
        bus.ls_wdata = '0;

        // Power-on reset
        repeat (2) step(1'b0, 1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Contention: IF reads 0x2, LSU loads 0x3 continuously -> LS,LS,LS,LS,IF repeating
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 10'h2, 1'b1, 1'b0, 1'b0, 10'h3, 32'h0,
                 cpat[i], !cpat[i], cpat[i] ? 32'hC0DE_0002 : 32'hC0DE_0003);
        end

        // Reset mid-burst with both requests high
        repeat (2) step(1'b1, 1'b1, 10'h2, 1'b1, 1'b0, 1'b0, 10'h3, 32'h0,
                        1'b0, 1'b1, 32'hC0DE_0003);
        repeat (2) step(1'b0, 1'b1, 10'h2, 1'b1, 1'b0, 1'b0, 10'h3, 32'h0,
                        1'b0, 1'b0, 32'h0);
        #1;
        chk("if_rdata in reset", bus.if_rdata, 32'h0);
        chk("ls_rdata in reset", bus.ls_rdata, 32'h0);
        chk("starve_q in reset", 32'(dut.r_starve), 32'd0);
        // Release: LSU wins first
        step(1'b1, 1'b1, 10'h2, 1'b1, 1'b0, 1'b0, 10'h3, 32'h0, 1'b0, 1'b1, 32'hC0DE_0003);
        step(1'b1, 1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Store then load to the same address
        step(1'b1, 1'b0, 10'h0, 1'b1, 1'b1, 1'b0, 10'h5, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0);
        step(1'b1, 1'b0, 10'h0, 1'b1, 1'b0, 1'b0, 10'h5, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Lock: locked load, then LSU absent for 6 cycles while IF waits
        step(1'b1, 1'b0, 10'h0, 1'b1, 1'b0, 1'b1, 10'h1, 32'h0, 1'b0, 1'b1, 32'hC0DE_0001);
        repeat (6) step(1'b1, 1'b1, 10'h0, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0,
                        1'b0, 1'b0, 32'h0);
        // Unlocking store still wins under lock; then starved IF is forced ahead of LSU
        step(1'b1, 1'b1, 10'h0, 1'b1, 1'b1, 1'b0, 10'h6, 32'h1234_5678, 1'b0, 1'b1, 32'h0);
        step(1'b1, 1'b1, 10'h0, 1'b1, 1'b0, 1'b0, 10'h6, 32'h0, 1'b1, 1'b0, 32'hC0DE_0000);
        step(1'b1, 1'b0, 10'h0, 1'b1, 1'b0, 1'b0, 10'h6, 32'h0, 1'b0, 1'b1, 32'h1234_5678);

        // IF only, back-to-back
        step(1'b1, 1'b1, 10'h0, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, 32'hC0DE_0000);
        step(1'b1, 1'b1, 10'h1, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, 32'hC0DE_0001);
        step(1'b1, 1'b1, 10'h2, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, 32'hC0DE_0002);
        step(1'b1, 1'b1, 10'h3, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, 32'hC0DE_0003);

        // Idle
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 32'h0);
            #2;
            chk("starve_q idle", 32'(dut.r_starve), 32'd0);
        end

        // Drain: every expectation must have been consumed
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard drained", 32'(gq.size() + ifq.size() + lsq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the single-port data memory `mem`. Shares the memory's one address/write/read path between the instruction-fetch port (read-only) and the load/store port (read/write), one access per cycle. Drives `mem`'s `rw`/`addr`/`wdata` and returns registered read data to the winning requester one cycle after its grant. LSU has fixed priority, bounded by an IF starvation counter and an LSU lock for read-modify-write sequences.

## Interface
- `DATA_W`, 32: data width; matches `mem` data width
- `ADDR_W`, 10: word-address width; matches `mem` address width
- `STARVE_MAX`, 4: consecutive denied IF-request cycles before IF is forced ahead of LSU; range 1..15
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch read request; held until granted
- `if_addr`  in  ADDR_W  fetch word address
- `if_gnt`  out  1  combinational; fetch access occurs this cycle
- `if_rvalid`  out  1  registered; `if_rdata` valid this cycle
- `if_rdata`  out  DATA_W  registered fetch read data
- `ls_req`  in  1  load/store request; held with stable fields until granted
- `ls_we`  in  1  1 = store, 0 = load
- `ls_lock`  in  1  keep LSU ownership after this access
- `ls_addr`  in  ADDR_W  load/store word address
- `ls_wdata`  in  DATA_W  store data
- `ls_gnt`  out  1  combinational; LSU access occurs this cycle (store commits at this edge)
- `ls_rvalid`  out  1  registered; pulses for loads only
- `ls_rdata`  out  DATA_W  registered load data
- `mem_rw`  out  1  to `mem` `rw`; 1 = write
- `mem_addr`  out  ADDR_W  to `mem` `addr`
- `mem_wdata`  out  DATA_W  to `mem` `wdata`
- `mem_rdata`  in  DATA_W  from `mem` (combinational read)

## Operation
- State: `lock_q` (1 b), `starve_q` (4 b saturating), `if_pend_q`/`ls_pend_q` (read-response pending), response data registers.
- Grant decision each cycle, at most one grant:
  - `lock_q`=1: grant LSU if `ls_req`; IF never granted (lock overrides starvation).
  - else `if_req` and `starve_q`==STARVE_MAX: grant IF.
  - else `ls_req`: grant LSU; else `if_req`: grant IF; else no grant.
- Memory drive: IF grant -> `mem_rw`=0, `mem_addr`=`if_addr`. LSU grant -> `mem_rw`=`ls_we`, `mem_addr`=`ls_addr`, `mem_wdata`=`ls_wdata`. No grant -> `mem_rw`=0, `mem_addr`=0, `mem_wdata`=0. `mem_rw` never 1 without `ls_gnt`.
- `starve_q`: cleared when IF granted or `if_req`=0; +1 when `if_req`=1 and IF not granted; saturates at STARVE_MAX.
- `lock_q`: on LSU grant, loads `ls_lock`; otherwise holds. Lock with `ls_req`=0 idles memory (no IF grant) until LSU returns.
- Read capture: on IF grant, `if_rdata` <= `mem_rdata`; on LSU load grant, `ls_rdata` <= `mem_rdata`. Data registers hold otherwise.

## Timing
- Grant cycle N: `*_gnt` high in N, memory addressed in N; store written at rising edge ending N.
- Read latency 1: `if_rvalid`/`ls_rvalid` high for exactly cycle N+1 with captured data; back-to-back grants give back-to-back rvalid pulses.
- Load after store to same address in consecutive cycles returns stored value (store lands at end of N, load reads in N+1).
- Reset (`rst`=0, async, any cycle): `lock_q`=0, `starve_q`=0, `if_rvalid`=`ls_rvalid`=0, `if_rdata`=`ls_rdata`=0; `if_gnt`=`ls_gnt`=0 and `mem_rw`=0 while `rst`=0 regardless of requests. In-flight responses dropped; store granted in reset-asserting cycle not guaranteed.
- Simultaneous `if_req` and `ls_req`: LSU wins unless starvation or lock rules apply.
- `ls_lock` sampled only on grant cycles.

## Test plan
- Reset: assert `rst`=0 mid-burst with both requests high -> all gnt/rvalid 0, `mem_rw`=0, data outputs 0; release -> LSU granted first cycle.
- Store then load: LSU store addr 0x05 data 0xDEADBEEF, next cycle load 0x05 -> `ls_gnt` both cycles, `ls_rvalid` in third cycle with `ls_rdata`=0xDEADBEEF; no `ls_rvalid` after store.
- Contention/starvation: STARVE_MAX=4, both requesting continuously -> pattern LS,LS,LS,LS,IF repeating; `if_rvalid` one cycle after each IF grant.
- Lock: LSU load with `ls_lock`=1, then `ls_req`=0 for 6 cycles with `if_req`=1 -> no grants, `mem_rw`=0; LSU store with `ls_lock`=0 -> next cycle IF granted.
- IF only: `if_req` at addresses 0x00..0x03 back-to-back -> `if_gnt` every cycle, `if_rvalid` continuous one cycle delayed, data matching preloaded words.
- Idle: no requests -> `mem_rw`=0, `mem_addr`=0, `starve_q` stays 0, no rvalid.
